// File: rtl/dsp_mult_sched.sv
// Round-robin scheduler sharing one dual 18x18 signed DSP among NUM_REQ requesters.
// Optional performance counters are enabled with `define DSP_SCHED_PERF_EN.

module dsp_2_18x18s #(
    parameter string FAMILY  = "Agilex",
    parameter int    LATENCY = 4
) (
    input  logic               clk,
    input  logic signed [17:0] ax,
    input  logic signed [17:0] ay,
    input  logic signed [17:0] bx,
    input  logic signed [17:0] by,
    output logic signed [35:0] resa,
    output logic signed [35:0] resb
);
    if (LATENCY < 2 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "dsp_2_18x18s: LATENCY must be 2..4");
    end
    if (FAMILY == "Arria 10" && LATENCY > 3) begin : g_bad_a10_latency
        $fatal(1, "dsp_2_18x18s: Arria 10 supports LATENCY 2..3");
    end

    logic signed [35:0] pipe_a [LATENCY];
    logic signed [35:0] pipe_b [LATENCY];

    // NOTE: the product pipeline is never reset; its contents are qualified by the tag valids.
    always_ff @(posedge clk) begin
        pipe_a[0] <= 36'(ax) * 36'(ay);
        pipe_b[0] <= 36'(bx) * 36'(by);
        for (int i = 1; i < LATENCY; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_b[i] <= pipe_b[i-1];
        end
    end

    assign resa = pipe_a[LATENCY-1];
    assign resb = pipe_b[LATENCY-1];
endmodule

module dsp_mult_sched #(
    parameter string FAMILY  = "Agilex",
    parameter int    LATENCY = 4,
    parameter int    NUM_REQ = 4,
    parameter int    ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*18-1:0]   req_x,
    input  logic [NUM_REQ*18-1:0]   req_y,
    output logic                    res_valid_a,
    output logic [ID_W-1:0]         res_id_a,
    output logic signed [35:0]      res_a,
    output logic                    res_valid_b,
    output logic [ID_W-1:0]         res_id_b,
    output logic signed [35:0]      res_b
`ifdef DSP_SCHED_PERF_EN
    ,
    input  logic                    perf_clr,
    output logic [31:0]             perf_busy,
    output logic [31:0]             perf_dual
`endif
);
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $fatal(1, "dsp_mult_sched: NUM_REQ must be 2..16");
    end

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

    logic signed [17:0] x_arr [NUM_REQ];
    logic signed [17:0] y_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign x_arr[g] = req_x[18*g +: 18];
        assign y_arr[g] = req_y[18*g +: 18];
    end

    logic [ID_W-1:0] rr_ptr, rr_next, last_id;
    logic [ID_W-1:0] sel_a, sel_b;
    logic            grant_a, grant_b;
    logic [ID_W:0]   idx;

    // NOTE: every variable gets a default before the scan so no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        sel_a   = '0;
        sel_b   = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
            if (en && req_valid[idx[ID_W-1:0]]) begin
                if (!grant_a) begin
                    grant_a = 1'b1;
                    sel_a   = idx[ID_W-1:0];
                end else if (!grant_b) begin
                    grant_b = 1'b1;
                    sel_b   = idx[ID_W-1:0];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_a) req_ready[sel_a] = 1'b1;
        if (grant_b) req_ready[sel_b] = 1'b1;
    end

    assign last_id = grant_b ? sel_b : sel_a;
    assign rr_next = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;

    tag_t               iss_a, iss_b;
    logic signed [17:0] iss_ax, iss_ay, iss_bx, iss_by;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            iss_a  <= '0;
            iss_b  <= '0;
        end else begin
            if (grant_a) rr_ptr <= rr_next;
            iss_a <= '{valid: grant_a, id: sel_a};
            iss_b <= '{valid: grant_b, id: sel_b};
        end
    end

    always_ff @(posedge clk) begin
        iss_ax <= grant_a ? x_arr[sel_a] : '0;
        iss_ay <= grant_a ? y_arr[sel_a] : '0;
        iss_bx <= grant_b ? x_arr[sel_b] : '0;
        iss_by <= grant_b ? y_arr[sel_b] : '0;
    end

    dsp_2_18x18s #(
        .FAMILY  (FAMILY),
        .LATENCY (LATENCY)
    ) u_dsp (
        .clk  (clk),
        .ax   (iss_ax),
        .ay   (iss_ay),
        .bx   (iss_bx),
        .by   (iss_by),
        .resa (res_a),
        .resb (res_b)
    );

    // Tags travel alongside the DSP stages so each product leaves with its requester ID.
    tag_t tag_a [LATENCY];
    tag_t tag_b [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_a[i] <= '0;
                tag_b[i] <= '0;
            end
        end else begin
            tag_a[0] <= iss_a;
            tag_b[0] <= iss_b;
            for (int i = 1; i < LATENCY; i++) begin
                tag_a[i] <= tag_a[i-1];
                tag_b[i] <= tag_b[i-1];
            end
        end
    end

    assign res_valid_a = tag_a[LATENCY-1].valid;
    assign res_id_a    = tag_a[LATENCY-1].id;
    assign res_valid_b = tag_b[LATENCY-1].valid;
    assign res_id_b    = tag_b[LATENCY-1].id;

`ifdef DSP_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy <= '0;
            perf_dual <= '0;
        end else if (perf_clr) begin
            perf_busy <= '0;
            perf_dual <= '0;
        end else begin
            if (grant_a && perf_busy != '1) perf_busy <= perf_busy + 1'b1;
            if (grant_b && perf_dual != '1) perf_dual <= perf_dual + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_dsp_mult_sched.sv
// Self-checking bench for dsp_mult_sched: directed scenarios plus random traffic
// against a queue-based scheduling model and a ring of expected results.

module tb_dsp_mult_sched;
    localparam int NUM_REQ = 4;
    localparam int LATENCY = 4;
    localparam int ID_W    = 2;
    localparam int RING    = 16;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  en = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '0;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*18-1:0] req_x = '0;
    logic [NUM_REQ*18-1:0] req_y = '0;
    logic                  res_valid_a, res_valid_b;
    logic [ID_W-1:0]       res_id_a, res_id_b;
    logic signed [35:0]    res_a, res_b;
`ifdef DSP_SCHED_PERF_EN
    logic                  perf_clr = 1'b0;
    logic [31:0]           perf_busy, perf_dual;
`endif

    dsp_mult_sched #(
        .FAMILY  ("Agilex"),
        .LATENCY (LATENCY),
        .NUM_REQ (NUM_REQ)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .res_valid_a (res_valid_a),
        .res_id_a    (res_id_a),
        .res_a       (res_a),
        .res_valid_b (res_valid_b),
        .res_id_b    (res_id_b),
        .res_b       (res_b)
`ifdef DSP_SCHED_PERF_EN
        ,
        .perf_clr    (perf_clr),
        .perf_busy   (perf_busy),
        .perf_dual   (perf_dual)
`endif
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    int     rr_m = 0;
    bit     ring_va [RING];
    bit     ring_vb [RING];
    int     ring_ia [RING];
    int     ring_ib [RING];
    longint ring_pa [RING];
    longint ring_pb [RING];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_op(input int i, input int x, input int y);
        req_x[18*i +: 18] = 18'(x);
        req_y[18*i +: 18] = 18'(y);
    endtask

    function automatic longint op_x(input int i);
        logic signed [17:0] v;
        v = req_x[18*i +: 18];
        return longint'(v);
    endfunction

    function automatic longint op_y(input int i);
        logic signed [17:0] v;
        v = req_y[18*i +: 18];
        return longint'(v);
    endfunction

    task automatic check_out();
        int s;
        s = cyc % RING;
        check("valid_a", 64'(res_valid_a), 64'(ring_va[s]));
        check("id_a", 64'(res_id_a), 64'(ring_ia[s]));
        check("valid_b", 64'(res_valid_b), 64'(ring_vb[s]));
        check("id_b", 64'(res_id_b), 64'(ring_ib[s]));
        if (ring_va[s]) check("prod_a", 64'(longint'(res_a)), ring_pa[s]);
        if (ring_vb[s]) check("prod_b", 64'(longint'(res_b)), ring_pb[s]);
    endtask

    // One clock: predict grants from the current inputs, then check the outputs after the edge.
    task automatic step();
        int                 order[$];
        int                 ga, gb, slot;
        logic [NUM_REQ-1:0] exp_ready;
        ga = -1;
        gb = -1;
        exp_ready = '0;
        #1;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[(rr_m + k) % NUM_REQ]) order.push_back((rr_m + k) % NUM_REQ);
            end
        end
        if (order.size() > 0) ga = order[0];
        if (order.size() > 1) gb = order[1];
        if (ga >= 0) exp_ready[ga] = 1'b1;
        if (gb >= 0) exp_ready[gb] = 1'b1;
        check("ready", 64'(req_ready), 64'(exp_ready));
        slot = (cyc + 1 + LATENCY) % RING;
        ring_va[slot] = (ga >= 0);
        ring_ia[slot] = (ga >= 0) ? ga : 0;
        ring_pa[slot] = (ga >= 0) ? op_x(ga) * op_y(ga) : 0;
        ring_vb[slot] = (gb >= 0);
        ring_ib[slot] = (gb >= 0) ? gb : 0;
        ring_pb[slot] = (gb >= 0) ? op_x(gb) * op_y(gb) : 0;
        if (gb >= 0) rr_m = (gb + 1) % NUM_REQ;
        else if (ga >= 0) rr_m = (ga + 1) % NUM_REQ;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_out();
    endtask

    task automatic reset_cycle();
        rst_n = 1'b0;
        #1;
        check("rst_valid_a", 64'(res_valid_a), 64'd0);
        check("rst_valid_b", 64'(res_valid_b), 64'd0);
        check("rst_id_a", 64'(res_id_a), 64'd0);
        check("rst_id_b", 64'(res_id_b), 64'd0);
        for (int i = 0; i < RING; i++) begin
            ring_va[i] = 1'b0;
            ring_vb[i] = 1'b0;
            ring_ia[i] = 0;
            ring_ib[i] = 0;
        end
        rr_m = 0;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("rst_hold_valid_a", 64'(res_valid_a), 64'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        reset_cycle();
        reset_cycle();

        // All requesters held valid from reset: pairs {0,1}, {2,3}, ...
        en = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 10 * (i + 1), -(i + 2));
        req_valid = 4'b1111;
        repeat (8) step();
        req_valid = '0;
        repeat (6) step();

        // Lone request lands on lane A only.
        for (int i = 0; i < NUM_REQ; i++) set_op(i, 0, 0);
        set_op(2, -3, 7);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (6) step();

        // Pointer now at 3: requesters 3 and 0 wrap onto lanes A and B.
        set_op(3, 1234, -56);
        set_op(0, -777, 999);
        req_valid = 4'b1001;
        step();
        req_valid = '0;
        repeat (6) step();

        // Operand extremes, pointer at 1: lane A <- requester 1, lane B <- requester 0.
        set_op(1, -131072, -131072);
        set_op(0, 131071, -131072);
        req_valid = 4'b0011;
        step();
        req_valid = '0;
        repeat (6) step();

        // Grant enable low with everyone requesting: nothing issued, pointer holds.
        req_valid = 4'b1111;
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (2) step();
        req_valid = '0;
        repeat (6) step();

        // Reset while two products are in flight: they must never surface.
        req_valid = 4'b1111;
        step();
        req_valid = '0;
        step();
        reset_cycle();
        repeat (8) step();
        req_valid = 4'b1111;
        repeat (2) step();
        req_valid = '0;
        repeat (6) step();

`ifdef DSP_SCHED_PERF_EN
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        req_valid = 4'b1111;
        repeat (10) step();
        req_valid = '0;
        step();
        check("perf_busy", 64'(perf_busy), 64'd10);
        check("perf_dual", 64'(perf_dual), 64'd10);
        perf_clr = 1'b1;
        step();
        perf_clr = 1'b0;
        check("perf_busy_clr", 64'(perf_busy), 64'd0);
        check("perf_dual_clr", 64'(perf_dual), 64'd0);
        repeat (5) step();
`endif

        // Random traffic with occasional enable drops.
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 7) != 0);
            req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) set_op(i, int'($urandom), int'($urandom));
            step();
        end
        req_valid = '0;
        repeat (LATENCY + 3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dsp_mult_sched.md
Name: dsp_mult_sched

Overview:
- Shares one dual 18x18 signed multiplier (instance of dsp_2_18x18s, lanes A and B) among NUM_REQ requesters.
- Each cycle it grants up to two single-product requests using round-robin arbitration and registers the selected operands into the multiplier.
- It carries a requester-ID tag pipeline alongside the multiplier, so each product comes back tagged with the requester that issued it.
- It sits between the tensor/filter engines that issue scalar multiplies and the single hard DSP block.

Parameters:
- FAMILY, "Agilex", passed unchanged to the multiplier; legal values are "Agilex", "Stratix 10", "Arria 10", or anything else for the behavioural model.
- LATENCY, 4, multiplier latency, passed through; legal range is 2..4 (2..3 for Arria 10).
- NUM_REQ, 4, number of requesters; legal range is 2..16; elaboration fails ($fatal) outside this range.
- ID_W, $clog2(NUM_REQ), width of the requester tag (derived; do not override).

Ports:
- clk, in, 1, clock; all logic is on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- en, in, 1, grant enable; when 0, no grants are issued and the pipeline keeps draining.
- req_valid, in, NUM_REQ, per-requester request valid.
- req_ready, out, NUM_REQ, per-requester grant (handshake completes when valid and ready are both 1).
- req_x, in, NUM_REQ*18, signed multiplicand; requester i uses slice [18*i+:18].
- req_y, in, NUM_REQ*18, signed multiplier; requester i uses slice [18*i+:18].
- res_valid_a, out, 1, lane A result valid.
- res_id_a, out, ID_W, lane A requester tag.
- res_a, out, 36, lane A signed product.
- res_valid_b, out, 1, lane B result valid.
- res_id_b, out, ID_W, lane B requester tag.
- res_b, out, 36, lane B signed product.

Behaviour:
- Arbitration is combinational from req_valid, en and the round-robin pointer rr_ptr (ID_W bits, reset value 0).
- Scan order is rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - The first valid requester found goes to lane A.
  - The second valid requester found goes to lane B.
  - A lone request always uses lane A; lane B is then idle.
- req_ready[i] is 1 only for the granted requesters; at most two bits are set; all bits are 0 when en=0 or no request is valid.
- req_ready may depend combinationally on req_valid. Requesters must not make req_valid depend on req_ready.
- rr_ptr update:
  - After a grant cycle, rr_ptr moves to (last granted index + 1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - Effect: a requester that keeps its request asserted is served at least once every ceil(NUM_REQ/2) cycles.
- Issue stage (one register level, registered on clk):
  - Lane A and lane B operands take the granted req_x/req_y values.
  - A valid bit and an ID are registered per lane.
  - An ungranted lane gets operands 0 and valid 0.
- Multiplier: the issue registers feed ax/ay (lane A) and bx/by (lane B).
- Tag pipeline: LATENCY stages of {valid, id} per lane, aligned so that res_valid_x/res_id_x match res_x exactly.
- Total latency: a handshake at edge T produces its result on the outputs after edge T+1+LATENCY.
- Arithmetic: full-precision 18x18 signed into 36 bits; no rounding and no saturation.
- The outputs have no backpressure. Consumers must accept results whenever res_valid is 1.
- Reset:
  - Asserting rst_n asynchronously clears rr_ptr, the issue valids and all tag valids.
  - res_valid_a, res_valid_b, res_id_a and res_id_b read 0 while reset is asserted and after it.
  - res_a and res_b come from the unreset DSP path and are don't-care while res_valid is 0.
  - Reset mid-operation drops every in-flight product silently; no result carrying a pre-reset ID may appear after reset.
- en falling while results are in flight: issued products still come out at their normal latency.
- Simultaneous request and reset: reset wins and no grant is recorded.

Optional Feature:
- Macro: DSP_SCHED_PERF_EN.
- Defined: adds ports perf_clr (in, 1), perf_busy (out, 32) and perf_dual (out, 32).
  - perf_busy counts cycles with at least one grant.
  - perf_dual counts cycles with two grants.
  - Both counters saturate at 32'hFFFF_FFFF.
  - Both clear on rst_n and synchronously on perf_clr.
  - If perf_clr and a grant occur in the same cycle, the counter becomes 0 (the clear wins).
- Undefined: these ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Single request: NUM_REQ=4, LATENCY=4, req_valid=4'b0100, x=-3, y=7 for one cycle -> req_ready=4'b0100; 5 cycles later res_valid_a=1, res_id_a=2, res_a=-21; res_valid_b stays 0.
- Dual grant and rotation: all four requesters held valid from reset -> grants {0,1}, {2,3}, {0,1}, ...; products return tagged in the same order.
- Wrap-around: rr_ptr=3 and req_valid=4'b1001 -> lane A gets ID 3, lane B gets ID 0; rr_ptr becomes 1.
- Extremes: x=y=-131072 on lane A and x=131071, y=-131072 on lane B -> res_a=36'sh4_0000_0000 and res_b=-17179738112.
- Reset mid-flight: issue 2 products, pulse rst_n low 1 cycle later -> no res_valid for the next 8 cycles; new requests then proceed normally with rr_ptr=0.
- en and perf: en=0 for 3 cycles with all requests valid -> req_ready=0, rr_ptr holds. With DSP_SCHED_PERF_EN, 10 dual-grant cycles -> perf_busy=10, perf_dual=10; perf_clr -> both 0.
